// File: rtl/mpc_types.sv
// Shared enums for the hit-test unit: request ops, memctl line ops
// and the lookup/issue FSM states.
package mpc_types;

    typedef enum logic [2:0] {
        OP_RD    = 3'd0,
        OP_WR    = 3'd1,
        OP_FLUSH = 3'd2
    } htu_op_e;

    typedef enum logic [2:0] {
        MC_RD = 3'd0,
        MC_WB = 3'd1
    } memctl_op_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_ISSUE  = 3'd2,
        S_MEM_WB = 3'd3,
        S_MEM_RD = 3'd4
    } htu_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim walk and touch update over a
// WAYS-1 bit node vector (node n has children 2n+1 / 2n+2).
module plru_tree #(
    parameter  int WAYS  = 4,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  state_i,
    input  logic [WAY_W-1:0] touch_way_i,
    output logic [WAY_W-1:0] victim_o,
    output logic [WAYS-2:0]  state_o
);

    logic [WAY_W-1:0] vnode;
    logic [WAY_W-1:0] tnode;

    always_comb begin
        victim_o = '0;
        vnode    = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim_o[WAY_W-1-l] = state_i[vnode];
            vnode = (vnode << 1) + WAY_W'(1)
                  + WAY_W'(state_i[vnode]);
        end
    end

    // Each node on the touched path is pointed at the other half.
    always_comb begin
        state_o = state_i;
        tnode   = '0;
        for (int l = 0; l < WAY_W; l++) begin
            state_o[tnode] = ~touch_way_i[WAY_W-1-l];
            tnode = (tnode << 1) + WAY_W'(1)
                  + WAY_W'(touch_way_i[WAY_W-1-l]);
        end
    end

endmodule

// File: rtl/htu_mshr.sv
// Blocking hit-test unit: tag lookup, PLRU victim choice, line locks,
// dirty write-back and refill requests towards memctl, issue to ISU.
module htu_mshr
    import mpc_types::*;
#(
    parameter  int SETS     = 8,
    parameter  int WAYS     = 4,
    parameter  int CHANNELS = 3,
    parameter  int ADDR_W   = 32,
    parameter  int OFFSET_W = 5,
    parameter  int WBUF_W   = 7,
    localparam int SET_W    = $clog2(SETS),
    localparam int WAY_W    = $clog2(WAYS),
    localparam int TAG_W    = ADDR_W - SET_W - OFFSET_W,
    localparam int ID_W     = WAY_W + SET_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                u_bank_req_valid,
    output logic                u_bank_req_ready,
    input  logic [CHANNELS-1:0] u_bank_req_ch_1hot,
    input  logic [2:0]          u_bank_req_op,
    input  logic [ADDR_W-1:0]   u_bank_req_addr,
    input  logic [WBUF_W-1:0]   u_bank_req_wbuf_id,
    output logic                d_isu_valid,
    input  logic                d_isu_ready,
    output logic [CHANNELS-1:0] d_isu_channel_1hot_id,
    output logic [2:0]          d_isu_op,
    output logic [ID_W-1:0]     d_isu_id,
    output logic [OFFSET_W-1:0] d_isu_offset,
    output logic [WBUF_W-1:0]   d_isu_wbuf_id,
    output logic                d_isu_hit,
    output logic                d_memctl_valid,
    input  logic                d_memctl_ready,
    output logic [2:0]          d_memctl_op,
    output logic [ID_W-1:0]     d_memctl_id,
    output logic [ADDR_W-1:0]   d_memctl_addr,
    input  logic                d_isu_refill_valid,
    input  logic [SET_W-1:0]    d_isu_refill_set,
    input  logic [WAY_W-1:0]    d_isu_refill_way,
    input  logic                d_isu_crdt_valid,
    input  logic [ID_W-1:0]     d_isu_crdt_way_set
);

    htu_state_e state_q, state_d;
    logic [CHANNELS-1:0] ch_q, ch_d;
    logic [2:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WBUF_W-1:0]   wbuf_q, wbuf_d;
    logic [WAY_W-1:0]    way_q, way_d;
    logic                hit_q, hit_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;

    logic [TAG_W-1:0] tag_q [SETS][WAYS];
    logic [TAG_W-1:0] tag_d [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0] dirty_q, dirty_d;
    logic [SETS-1:0][WAYS-1:0] busy_q, busy_d;
    logic [SETS-1:0][WAYS-2:0] plru_q, plru_d;

    logic [SET_W-1:0]  set;
    logic [TAG_W-1:0]  tag;
    logic [ADDR_W-1:0] line_addr;
    logic              is_wr, is_flush;
    logic              hit_any, inv_any, nb_any, vic_ok;
    logic [WAY_W-1:0]  hit_way, inv_way, nb_way, cand, vic_way;
    logic [WAY_W-1:0]  plru_vic, touch_way;
    logic [WAYS-2:0]   plru_nxt;

    assign set       = addr_q[OFFSET_W +: SET_W];
    assign tag       = addr_q[ADDR_W-1 -: TAG_W];
    assign line_addr = {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    assign is_wr     = (op_q == OP_WR);
    assign is_flush  = (op_q == OP_FLUSH);

    // Downward scans leave the lowest matching index in each result.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        inv_any = 1'b0;
        inv_way = '0;
        nb_any  = 1'b0;
        nb_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[set][WAY_W'(w)]
                && tag_q[set][w] == tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[set][WAY_W'(w)]) begin
                inv_any = 1'b1;
                inv_way = WAY_W'(w);
            end
            if (!busy_q[set][WAY_W'(w)]) begin
                nb_any = 1'b1;
                nb_way = WAY_W'(w);
            end
        end
        cand    = inv_any ? inv_way : plru_vic;
        vic_ok  = !busy_q[set][cand] || nb_any;
        vic_way = busy_q[set][cand] ? nb_way : cand;
    end

    assign touch_way = hit_any ? hit_way : vic_way;

    plru_tree #(.WAYS(WAYS)) u_plru (
        .state_i     (plru_q[set]),
        .touch_way_i (touch_way),
        .victim_o    (plru_vic),
        .state_o     (plru_nxt)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wbuf_d    = wbuf_q;
        way_d     = way_q;
        hit_d     = hit_q;
        wb_addr_d = wb_addr_q;
        tag_d     = tag_q;
        valid_d   = valid_q;
        dirty_d   = dirty_q;
        busy_d    = busy_q;
        plru_d    = plru_q;

        u_bank_req_ready      = 1'b0;
        d_isu_valid           = 1'b0;
        d_isu_channel_1hot_id = '0;
        d_isu_op              = '0;
        d_isu_id              = '0;
        d_isu_offset          = '0;
        d_isu_wbuf_id         = '0;
        d_isu_hit             = 1'b0;
        d_memctl_valid        = 1'b0;
        d_memctl_op           = '0;
        d_memctl_id           = '0;
        d_memctl_addr         = '0;

        if (d_isu_refill_valid)
            valid_d[d_isu_refill_set][d_isu_refill_way] = 1'b1;
        if (d_isu_crdt_valid)
            busy_d[d_isu_crdt_way_set[SET_W-1:0]]
                  [d_isu_crdt_way_set[ID_W-1:SET_W]] = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                u_bank_req_ready = rst_n;
                if (u_bank_req_valid) begin
                    ch_d    = u_bank_req_ch_1hot;
                    op_d    = u_bank_req_op;
                    addr_d  = u_bank_req_addr;
                    wbuf_d  = u_bank_req_wbuf_id;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // A busy hit, or no unlocked victim, retries next cycle.
                if (hit_any && busy_q[set][hit_way]) begin
                    state_d = S_LOOKUP;
                end else if (is_flush) begin
                    way_d = hit_any ? hit_way : '0;
                    hit_d = hit_any;
                    if (hit_any && dirty_q[set][hit_way]) begin
                        wb_addr_d = line_addr;
                        state_d   = S_MEM_WB;
                    end else begin
                        if (hit_any) begin
                            valid_d[set][hit_way] = 1'b0;
                            dirty_d[set][hit_way] = 1'b0;
                        end
                        state_d = S_ISSUE;
                    end
                end else if (hit_any) begin
                    busy_d[set][hit_way] = 1'b1;
                    if (is_wr) dirty_d[set][hit_way] = 1'b1;
                    plru_d[set] = plru_nxt;
                    way_d       = hit_way;
                    hit_d       = 1'b1;
                    state_d     = S_ISSUE;
                end else if (vic_ok) begin
                    way_d     = vic_way;
                    hit_d     = 1'b0;
                    wb_addr_d = {tag_q[set][vic_way], set,
                                 {OFFSET_W{1'b0}}};
                    tag_d[set][vic_way]   = tag;
                    valid_d[set][vic_way] = 1'b0;
                    dirty_d[set][vic_way] = is_wr;
                    busy_d[set][vic_way]  = 1'b1;
                    plru_d[set] = plru_nxt;
                    state_d = dirty_q[set][vic_way] ? S_MEM_WB
                                                    : S_MEM_RD;
                end
            end
            S_MEM_WB: begin
                d_memctl_valid = 1'b1;
                d_memctl_op    = MC_WB;
                d_memctl_id    = {way_q, set};
                d_memctl_addr  = wb_addr_q;
                if (d_memctl_ready) begin
                    if (is_flush) begin
                        valid_d[set][way_q] = 1'b0;
                        dirty_d[set][way_q] = 1'b0;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_MEM_RD;
                    end
                end
            end
            S_MEM_RD: begin
                d_memctl_valid = 1'b1;
                d_memctl_op    = MC_RD;
                d_memctl_id    = {way_q, set};
                d_memctl_addr  = line_addr;
                if (d_memctl_ready) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                d_isu_valid           = 1'b1;
                d_isu_channel_1hot_id = ch_q;
                d_isu_op              = op_q;
                d_isu_id              = {way_q, set};
                d_isu_offset          = addr_q[OFFSET_W-1:0];
                d_isu_wbuf_id         = wbuf_q;
                d_isu_hit             = hit_q;
                if (d_isu_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            wbuf_q    <= '0;
            way_q     <= '0;
            hit_q     <= 1'b0;
            wb_addr_q <= '0;
            tag_q     <= '{default: '0};
            valid_q   <= '0;
            dirty_q   <= '0;
            busy_q    <= '0;
            plru_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wbuf_q    <= wbuf_d;
            way_q     <= way_d;
            hit_q     <= hit_d;
            wb_addr_q <= wb_addr_d;
            tag_q     <= tag_d;
            valid_q   <= valid_d;
            dirty_q   <= dirty_d;
            busy_q    <= busy_d;
            plru_q    <= plru_d;
        end
    end

endmodule

// File: tb/tb_htu_mshr.sv
// Randomised bench for htu_mshr against a transaction-level cache model.
module tb_htu_mshr;

    localparam int SETS = 8, WAYS = 4, CHANNELS = 3;
    localparam int ADDR_W = 32, OFFSET_W = 5, WBUF_W = 7;
    localparam int SET_W = 3, WAY_W = 2, ID_W = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic u_bank_req_valid = 1'b0;
    logic u_bank_req_ready;
    logic [CHANNELS-1:0] u_bank_req_ch_1hot = '0;
    logic [2:0] u_bank_req_op = '0;
    logic [ADDR_W-1:0] u_bank_req_addr = '0;
    logic [WBUF_W-1:0] u_bank_req_wbuf_id = '0;
    logic d_isu_valid;
    logic d_isu_ready = 1'b0;
    logic [CHANNELS-1:0] d_isu_channel_1hot_id;
    logic [2:0] d_isu_op;
    logic [ID_W-1:0] d_isu_id;
    logic [OFFSET_W-1:0] d_isu_offset;
    logic [WBUF_W-1:0] d_isu_wbuf_id;
    logic d_isu_hit;
    logic d_memctl_valid;
    logic d_memctl_ready = 1'b0;
    logic [2:0] d_memctl_op;
    logic [ID_W-1:0] d_memctl_id;
    logic [ADDR_W-1:0] d_memctl_addr;
    logic d_isu_refill_valid = 1'b0;
    logic [SET_W-1:0] d_isu_refill_set = '0;
    logic [WAY_W-1:0] d_isu_refill_way = '0;
    logic d_isu_crdt_valid = 1'b0;
    logic [ID_W-1:0] d_isu_crdt_way_set = '0;

    always #5 clk = ~clk;

    htu_mshr #(
        .SETS(SETS), .WAYS(WAYS), .CHANNELS(CHANNELS),
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .WBUF_W(WBUF_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .u_bank_req_valid(u_bank_req_valid),
        .u_bank_req_ready(u_bank_req_ready),
        .u_bank_req_ch_1hot(u_bank_req_ch_1hot),
        .u_bank_req_op(u_bank_req_op),
        .u_bank_req_addr(u_bank_req_addr),
        .u_bank_req_wbuf_id(u_bank_req_wbuf_id),
        .d_isu_valid(d_isu_valid), .d_isu_ready(d_isu_ready),
        .d_isu_channel_1hot_id(d_isu_channel_1hot_id),
        .d_isu_op(d_isu_op), .d_isu_id(d_isu_id),
        .d_isu_offset(d_isu_offset),
        .d_isu_wbuf_id(d_isu_wbuf_id), .d_isu_hit(d_isu_hit),
        .d_memctl_valid(d_memctl_valid),
        .d_memctl_ready(d_memctl_ready),
        .d_memctl_op(d_memctl_op), .d_memctl_id(d_memctl_id),
        .d_memctl_addr(d_memctl_addr),
        .d_isu_refill_valid(d_isu_refill_valid),
        .d_isu_refill_set(d_isu_refill_set),
        .d_isu_refill_way(d_isu_refill_way),
        .d_isu_crdt_valid(d_isu_crdt_valid),
        .d_isu_crdt_way_set(d_isu_crdt_way_set)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference cache state: tags, flags and PLRU tree nodes per set.
    int unsigned m_tag [SETS][WAYS];
    bit m_val [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    bit m_busy [SETS][WAYS];
    bit m_node [SETS][WAYS-1];
    int unlock_way = -1;
    logic [CHANNELS-1:0] cur_ch;
    logic [WBUF_W-1:0] cur_wbuf;

    function automatic void m_reset();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) begin
                m_tag[s][w] = 0; m_val[s][w] = 0;
                m_dirty[s][w] = 0; m_busy[s][w] = 0;
                if (w < WAYS - 1) m_node[s][w] = 0;
            end
    endfunction

    function automatic int plru_victim(input int s);
        int n = 0, way = 0;
        for (int l = 0; l < WAY_W; l++) begin
            way = way * 2 + int'(m_node[s][n]);
            n = 2 * n + 1 + int'(m_node[s][n]);
        end
        return way;
    endfunction

    function automatic void plru_touch(input int s, input int way);
        int n = 0, b;
        for (int l = 0; l < WAY_W; l++) begin
            b = (way >> (WAY_W - 1 - l)) & 1;
            m_node[s][n] = (b == 0);
            n = 2 * n + 1 + b;
        end
    endfunction

    // Returns 0 when the lookup must retry; otherwise updates the model.
    function automatic bit m_lookup(
        input int op, input int unsigned addr,
        output bit do_wb, output bit do_rd, output int way,
        output bit hit, output int unsigned wb_addr,
        output int stall_way);
        int s = (addr >> 5) & 7;
        int unsigned t = addr >> 8;
        int hw = -1, v = -1;
        do_wb = 0; do_rd = 0; way = 0; hit = 0;
        wb_addr = 0; stall_way = -1;
        for (int w = 0; w < WAYS; w++)
            if (hw < 0 && m_val[s][w] && m_tag[s][w] == t) hw = w;
        if (hw >= 0 && m_busy[s][hw]) begin
            stall_way = hw;
            return 0;
        end
        if (op == 2) begin
            if (hw >= 0) begin
                way = hw; hit = 1;
                do_wb = m_dirty[s][hw];
                wb_addr = addr & ~32'h1f;
                m_val[s][hw] = 0; m_dirty[s][hw] = 0;
            end
            return 1;
        end
        if (hw >= 0) begin
            m_busy[s][hw] = 1;
            if (op == 1) m_dirty[s][hw] = 1;
            plru_touch(s, hw);
            way = hw; hit = 1;
            return 1;
        end
        for (int w = 0; w < WAYS; w++)
            if (v < 0 && !m_val[s][w]) v = w;
        if (v < 0) v = plru_victim(s);
        if (m_busy[s][v]) begin
            v = -1;
            for (int w = 0; w < WAYS; w++)
                if (v < 0 && !m_busy[s][w]) v = w;
        end
        if (v < 0) return 0;
        way = v; do_rd = 1;
        do_wb = m_dirty[s][v];
        wb_addr = (m_tag[s][v] << 8) | (s << 5);
        m_tag[s][v] = t; m_val[s][v] = 0;
        m_dirty[s][v] = (op == 1); m_busy[s][v] = 1;
        plru_touch(s, v);
        return 1;
    endfunction

    task automatic refill(input int s, input int w);
        d_isu_refill_valid = 1'b1;
        d_isu_refill_set = SET_W'(s);
        d_isu_refill_way = WAY_W'(w);
        @(negedge clk);
        d_isu_refill_valid = 1'b0;
        m_val[s][w] = 1;
    endtask

    task automatic crdt(input int s, input int w);
        d_isu_crdt_valid = 1'b1;
        d_isu_crdt_way_set = ID_W'((w << SET_W) | s);
        @(negedge clk);
        d_isu_crdt_valid = 1'b0;
        m_busy[s][w] = 0;
    endtask

    task automatic send(input logic [2:0] op, input int unsigned addr);
        bit ok = 0;
        cur_ch = CHANNELS'(1 << $urandom_range(0, CHANNELS - 1));
        cur_wbuf = WBUF_W'($urandom);
        u_bank_req_valid = 1'b1;
        u_bank_req_op = op;
        u_bank_req_addr = addr;
        u_bank_req_ch_1hot = cur_ch;
        u_bank_req_wbuf_id = cur_wbuf;
        for (int i = 0; i < 40; i++) begin
            if (u_bank_req_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(negedge clk);
        u_bank_req_valid = 1'b0;
        u_bank_req_op = 3'($urandom);
        u_bank_req_addr = $urandom;
        u_bank_req_wbuf_id = WBUF_W'($urandom);
    endtask

    task automatic mem_phase(input logic [2:0] op, input int unsigned addr,
                             input int id, input int dly);
        bit ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (d_memctl_valid) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin chk("mc_timeout", 0, 1); return; end
        for (int k = 0; k <= dly; k++) begin
            chk("mc_valid", d_memctl_valid, 1);
            chk("mc_op", d_memctl_op, op);
            chk("mc_addr", d_memctl_addr, addr);
            chk("mc_id", d_memctl_id, id);
            chk("mc_isu_quiet", d_isu_valid, 0);
            if (k == dly) d_memctl_ready = 1'b1;
            @(negedge clk);
        end
        d_memctl_ready = 1'b0;
    endtask

    task automatic do_req(input logic [2:0] op, input int unsigned addr,
                          input int mdly, input int idly, input bit post,
                          output int lat);
        bit go = 0, do_wb, do_rd, hit;
        int way, sw, uw;
        int s = (addr >> 5) & 7;
        int unsigned wb_addr;
        lat = 0;
        send(op, addr);
        for (int it = 0; it < 10; it++) begin
            go = m_lookup(int'(op), addr, do_wb, do_rd, way, hit,
                          wb_addr, sw);
            if (go) break;
            repeat (3) begin
                chk("stall_ready", u_bank_req_ready, 0);
                chk("stall_isu", d_isu_valid, 0);
                chk("stall_mc", d_memctl_valid, 0);
                @(negedge clk);
            end
            uw = (sw >= 0) ? sw : (unlock_way >= 0) ? unlock_way
                                : int'($urandom_range(0, WAYS - 1));
            crdt(s, uw);
        end
        if (!go) begin chk("stall_bound", 0, 1); return; end
        if (do_wb) mem_phase(3'd1, wb_addr, (way << 3) | s, mdly);
        if (do_rd) mem_phase(3'd0, addr & ~32'h1f, (way << 3) | s, mdly);
        lat = 1;
        while (!d_isu_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k <= idly; k++) begin
            chk("isu_valid", d_isu_valid, 1);
            chk("isu_ch", d_isu_channel_1hot_id, cur_ch);
            chk("isu_op", d_isu_op, op);
            chk("isu_id", d_isu_id, (way << 3) | s);
            chk("isu_offset", d_isu_offset, addr & 32'h1f);
            chk("isu_wbuf", d_isu_wbuf_id, cur_wbuf);
            chk("isu_hit", d_isu_hit, hit);
            chk("isu_mc_quiet", d_memctl_valid, 0);
            chk("isu_no_accept", u_bank_req_ready, 0);
            if (k == idly) d_isu_ready = 1'b1;
            @(negedge clk);
        end
        d_isu_ready = 1'b0;
        if (post) begin
            if (do_rd && $urandom_range(0, 3) != 0) refill(s, way);
            if (m_busy[s][way] && $urandom_range(0, 3) != 0)
                crdt(s, way);
        end
    endtask

    initial begin
        int lat;
        int unsigned a;
        logic [2:0] op;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_ready", u_bank_req_ready, 0);
        chk("rst_isu_valid", d_isu_valid, 0);
        chk("rst_mc_valid", d_memctl_valid, 0);
        chk("rst_isu_id", d_isu_id, 0);
        chk("rst_mc_addr", d_memctl_addr, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", u_bank_req_ready, 1);

        do_req(3'd0, 32'h10, 0, 0, 0, lat);
        refill(0, 0);
        crdt(0, 0);
        do_req(3'd0, 32'h10, 0, 0, 0, lat);
        chk("hit_latency", lat, 2);
        crdt(0, 0);

        do_req(3'd1, 32'h14, 0, 0, 0, lat);
        crdt(0, 0);
        for (int t = 1; t < 4; t++) begin
            do_req(3'd0, t << 8, 1, 0, 0, lat);
            refill(0, t);
            crdt(0, t);
        end
        do_req(3'd0, 32'h400, 2, 1, 0, lat);

        for (int t = 1; t < 5; t++)
            do_req(3'd0, (t << 8) | 32'h20, 0, 0, 0, lat);
        unlock_way = 2;
        do_req(3'd0, 32'h520, 0, 0, 0, lat);
        unlock_way = -1;
        for (int w = 0; w < WAYS; w++) begin
            refill(1, w);
            crdt(1, w);
        end

        refill(0, 0);
        crdt(0, 0);
        do_req(3'd1, 32'h404, 0, 0, 0, lat);
        crdt(0, 0);
        do_req(3'd2, 32'h400, 1, 0, 0, lat);
        do_req(3'd0, 32'h400, 0, 0, 0, lat);
        refill(0, 0);
        crdt(0, 0);

        do_req(3'd0, 32'h408, 0, 5, 0, lat);
        crdt(0, 0);

        for (int n = 0; n < 250; n++) begin
            a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 3) << 5)
              | $urandom_range(0, 31);
            case ($urandom_range(0, 19))
                0, 1, 2, 3, 4, 5, 6, 7, 8, 9: op = 3'd0;
                10, 11, 12, 13, 14, 15: op = 3'd1;
                16, 17, 18: op = 3'd2;
                default: op = 3'($urandom_range(3, 7));
            endcase
            do_req(op, a, $urandom_range(0, 3), $urandom_range(0, 3),
                   1, lat);
        end

        send(3'd0, 32'h7e0);
        for (int i = 0; i < 30 && !d_memctl_valid; i++) @(negedge clk);
        chk("rst_mid_mc_seen", d_memctl_valid, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready_now", u_bank_req_ready, 0);
        @(negedge clk);
        chk("rst_mid_mc", d_memctl_valid, 0);
        chk("rst_mid_isu", d_isu_valid, 0);
        chk("rst_mid_ready", u_bank_req_ready, 0);
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
        do_req(3'd0, 32'h10, 0, 0, 0, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
